// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_shift;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // Full-adder cell built from two half adders plus an OR on the carries
    logic w_ha0_s;
    logic w_ha0_c;
    logic w_ha1_s;
    logic w_ha1_c;
    logic w_cell_s;
    logic w_cell_c;
    logic [WIDTH-1:0] w_res_next;

    assign w_ha0_s    = r_a[0] ^ r_b[0];
    assign w_ha0_c    = r_a[0] & r_b[0];
    assign w_ha1_s    = w_ha0_s ^ r_carry;
    assign w_ha1_c    = w_ha0_s & r_carry;
    assign w_cell_s   = w_ha1_s;
    assign w_cell_c   = w_ha0_c | w_ha1_c;
    assign w_res_next = {w_cell_s, r_res};

    // Next-state and datapath control
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from the carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_cell_c;
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_SHIFT);
            r_done  <= (w_state_next == S_DONE);
            if (w_load) begin
                r_a     <= a;
                r_b     <= b;
                r_res   <= '0;
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end
            if (w_shift) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_res   <= w_res_next[WIDTH-1:1];
                r_carry <= w_cell_c;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_cell_c;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that wraps a single-bit adder cell (two `halfAdder` instances plus an OR for carry) with operand shift registers, a carry flip-flop, a bit counter and a control FSM. The block consumes the cell's `sum`/`cout` each cycle, feeds `cout` back as next-cycle carry-in, and presents a registered WIDTH-bit result with a one-cycle `done` strobe. It is the sequential stage built around the half-adder cell, trading area for WIDTH cycles of latency.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous reset, active-low.
- `start`  input  1  request to add `a` and `b`; sampled only in IDLE.
- `a`  input  WIDTH  operand A, captured on the accepted `start` edge.
- `b`  input  WIDTH  operand B, captured on the accepted `start` edge.
- `busy`  output  1  high in SHIFT state.
- `done`  output  1  one-cycle strobe, high in DONE state.
- `sum`  output  WIDTH  result register; holds until next completion or reset.
- `cout`  output  1  final carry-out register; holds like `sum`.
- `ovf`  output  1  signed overflow; present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, carry FF=0, counter=0, shift regs=0. `start` ignored while `rst_n`=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on `start`=1, load `a`/`b` into shift regs, clear carry FF and counter, go to SHIFT. `sum`/`cout` keep previous values.
- SHIFT, each edge: cell inputs are shift-reg bit 0 of A, bit 0 of B and the carry FF. Cell sum bit shifts into the result shift reg at MSB (right shift, LSB first). Carry FF takes cell carry. A/B shift right. Counter increments.
- On the shift edge where counter = WIDTH-1: the result shift reg contents (including this bit) load into `sum`, the cell carry loads into `cout`, and the state goes to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally. `start` in DONE is ignored.
- `start` in SHIFT or DONE is ignored. No queueing.
- Arithmetic: unsigned modulo 2^WIDTH. {`cout`,`sum`} = a + b exactly.
- Operands changing after capture have no effect.

## Timing
- Accepted `start` at edge E0. SHIFT spans edges E1..E_WIDTH. `busy` is high from after E0 through E_WIDTH-1, which is WIDTH cycles.
- `sum`/`cout` update at edge E_WIDTH. `done` is high for the cycle between E_WIDTH and E_WIDTH+1.
- Next `start` can be accepted at E_WIDTH+2. Minimum issue interval is WIDTH+2 cycles.
- Reset mid-operation: at the reset edge the FSM returns to IDLE, all outputs clear, and the partial result is discarded.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - Adds port `ovf`. A carry-into-MSB FF captures the carry FF value at the final shift.
  - `ovf` = carry_into_MSB XOR final carry. It loads with `sum`, resets to 0 and holds with `sum`.
- `SERIAL_ADDER_OVF_EN` undefined: the `ovf` port and its FF do not exist. All other behaviour is identical.

## Test plan
- WIDTH=8, reset, then `start` with a=8'h0F, b=8'h01 at E0:
  - `busy` is high for 8 cycles.
  - `done` pulses once after E8.
  - `sum`=8'h10, `cout`=0.
- a=8'hFF, b=8'h01: `sum`=8'h00, `cout`=1, `ovf`=0 (OVF build).
- a=8'h7F, b=8'h01: `sum`=8'h80, `cout`=0, `ovf`=1. Separately, a=8'h80, b=8'h80: `sum`=8'h00, `cout`=1, `ovf`=1.
- a=8'h3C, b=8'h05 accepted. Then pulse `start` with a=8'hFF, b=8'hFF during SHIFT and again in DONE:
  - Only a single `done` occurs.
  - `sum`=8'h41, `cout`=0.
  - `busy` does not re-assert until a new `start` in IDLE.
- Start a=8'hAA, b=8'h55. Drop `rst_n` at E4 for one cycle, then release:
  - `busy`=0, `done`=0, `sum`=0, `cout`=0 after that edge.
  - No `done` follows.
  - A new `start` with a=8'h01, b=8'h02 yields `sum`=8'h03.
- Back-to-back: issue `start` at E_WIDTH+2 after previous completion with a=8'h12, b=8'h34:
  - Accepted, `sum`=8'h46.
  - The previous `sum` is held until E_WIDTH of the new operation.
